// File: rtl/alu_pkg.sv
// Shared ALU control-code constants and the result-buffer entry layout.
// Used by alu_result_stage (optional overflow trap: ALU_OVF_TRAP_EN).
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_AND = 4'b1101;
    // OR has no slot of its own; it shares 1100 and, like every non add/sub code, never flags overflow.
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

    localparam int unsigned OVF_CNT_W = 8;

    // Status bits carried with each buffered result; the full entry is {r, dest, res_flags_t}.
    typedef struct packed {
        logic o_eff;
        logic n;
        logic z;
    } res_flags_t;

    function automatic logic ovf_applies(input logic [3:0] crtl);
        return (crtl == OP_ADD) || (crtl == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU, the result stage and writeback, plus status outputs.
// trap/ovf_cnt are live only when ALU_OVF_TRAP_EN is defined.
interface alu_result_stage_if #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 4
);
    // Handshakes: a transfer happens on a rising clk where valid && ready; valid never
    // depends combinationally on ready, and ready/valid from the stage come from registers.
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_r;
    logic              in_o;
    logic [3:0]        in_crtl;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_r;
    logic [DEST_W-1:0] out_dest;
    logic              flag_o;
    logic              flag_n;
    logic              flag_z;
    logic              trap;
    logic [7:0]        ovf_cnt;
    logic [1:0]        dbg_occ;

    modport master (
        output in_valid, in_r, in_o, in_crtl, in_dest, out_ready,
        input  in_ready, out_valid, out_r, out_dest,
        input  flag_o, flag_n, flag_z, trap, ovf_cnt, dbg_occ
    );

    modport slave (
        input  in_valid, in_r, in_o, in_crtl, in_dest, out_ready,
        output in_ready, out_valid, out_r, out_dest,
        output flag_o, flag_n, flag_z, trap, ovf_cnt, dbg_occ
    );

endinterface

// File: rtl/res_fifo2.sv
// Two-entry in-order valid/ready buffer; head is a register so outputs never see inputs combinationally.
// The head keeps its last contents when the buffer drains.
module res_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    logic [1:0]    cnt;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          push;
    logic          pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign occ       = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) head <= tail;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable at occupancy 1: the new entry replaces the retiring head.
                    if (cnt == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results with precomputed flags, loads status flags on retire.
// Define ALU_OVF_TRAP_EN to enable the overflow trap pulse and saturating ovf_cnt.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 4
) (
    input logic               clk,
    input logic               rst,
    alu_result_stage_if.slave bus
);

    localparam int EW = WIDTH + DEST_W + $bits(res_flags_t);

    res_flags_t    in_flags;
    res_flags_t    head_flags;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic          retire;

    // Flags are derived at accept time so retire only has to copy them.
    assign in_flags.o_eff = bus.in_o & ovf_applies(bus.in_crtl);
    assign in_flags.n     = bus.in_r[WIDTH-1];
    assign in_flags.z     = (bus.in_r == '0);
    assign in_entry       = {bus.in_r, bus.in_dest, in_flags};

    res_fifo2 #(.DW(EW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head_entry),
        .occ       (bus.dbg_occ)
    );

    assign {bus.out_r, bus.out_dest, head_flags} = head_entry;
    assign retire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.flag_o <= 1'b0;
            bus.flag_n <= 1'b0;
            bus.flag_z <= 1'b0;
        end else if (retire) begin
            bus.flag_o <= head_flags.o_eff;
            bus.flag_n <= head_flags.n;
            bus.flag_z <= head_flags.z;
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic [OVF_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.trap <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bus.trap <= retire && head_flags.o_eff;
            if (retire && head_flags.o_eff && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.ovf_cnt = cnt_q;
`else
    assign bus.trap    = 1'b0;
    assign bus.ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, corner sequences and random traffic
// against a queue-based reference model. Honours ALU_OVF_TRAP_EN for trap/ovf_cnt expectations.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DEST_W = 4;
    localparam int QW     = WIDTH + DEST_W + 1;
`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(WIDTH), .DEST_W(DEST_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEST_W(DEST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard / model state ----------------
    int checks   = 0;
    int failures = 0;
    logic [QW-1:0]     exp_q[$];   // {r, dest, o_eff} in arrival order
    logic              m_o, m_n, m_z, m_trap;
    int                m_cnt;
    logic [WIDTH-1:0]  m_last_r;
    logic [DEST_W-1:0] m_last_dest;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_o = 0; m_n = 0; m_z = 0; m_trap = 0; m_cnt = 0;
        m_last_r = '0; m_last_dest = '0;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() < 2));
        chk("occupancy", 32'(bus.dbg_occ),   32'(exp_q.size()));
        chk("out_r",     32'(bus.out_r),     32'(m_last_r));
        chk("out_dest",  32'(bus.out_dest),  32'(m_last_dest));
        chk("flag_o",    32'(bus.flag_o),    32'(m_o));
        chk("flag_n",    32'(bus.flag_n),    32'(m_n));
        chk("flag_z",    32'(bus.flag_z),    32'(m_z));
        chk("trap",      32'(bus.trap),      32'(m_trap));
        chk("ovf_cnt",   32'(bus.ovf_cnt),   32'(m_cnt));
    endtask

    // ---------------- driver: one clock of traffic, then model update and check ----------------
    task automatic step(input logic iv, input logic [WIDTH-1:0] r, input logic o,
                        input logic [3:0] crtl, input logic [DEST_W-1:0] dest,
                        input logic ordy, output bit acc, output bit ret);
        logic [QW-1:0]    e;
        logic [WIDTH-1:0] rr;
        bus.in_valid  = iv;
        bus.in_r      = r;
        bus.in_o      = o;
        bus.in_crtl   = crtl;
        bus.in_dest   = dest;
        bus.out_ready = ordy;
        acc = iv && (exp_q.size() < 2);
        ret = ordy && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        m_trap = 1'b0;
        if (ret) begin
            e    = exp_q.pop_front();
            rr   = e[QW-1 -: WIDTH];
            m_o  = e[0];
            m_n  = (int'(rr) >= (1 << (WIDTH - 1)));
            m_z  = (rr == 0);
            if (TRAP_EN && m_o) begin
                m_trap = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (acc) exp_q.push_back({r, dest, o && (crtl == OP_ADD || crtl == OP_SUB)});
        if (exp_q.size() > 0) begin
            m_last_r    = exp_q[0][QW-1 -: WIDTH];
            m_last_dest = exp_q[0][DEST_W:1];
        end
        check_all();
    endtask

    task automatic idle_step(input logic ordy, output bit ret);
        bit a;
        step(1'b0, '0, 1'b0, 4'b0000, '0, ordy, a, ret);
    endtask

    task automatic drain();
        bit r;
        for (int i = 0; i < 3; i++) idle_step(1'b1, r);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_r = '0; bus.in_o = 0; bus.in_crtl = '0;
        bus.in_dest = '0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] r;
        logic             o;
        logic [3:0]       crtl;
        logic [DEST_W-1:0] dest;
        logic             exp_o;
        logic             exp_n;
        logic             exp_z;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit a, rt;
        int nret;
        logic [WIDTH-1:0] ra, rb, rc, rv;

        vecs[0] = '{16'h0000, 1'b0, OP_AND, 4'h1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h8000, 1'b1, OP_ADD, 4'h2, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 1'b1, OP_MUL, 4'h3, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h7fff, 1'b1, OP_SUB, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hffff, 1'b1, 4'b0000, 4'h5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 1'b1, 4'b0101, 4'h6, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 1'b1, OP_ADD, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8001, 1'b1, 4'b1100, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h0001, 1'b0, OP_SUB, 4'hf, 1'b0, 1'b0, 1'b0};

        apply_reset();

        // Table: accept right after reset/idle, then retire and compare flags to the table.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].r, vecs[i].o, vecs[i].crtl, vecs[i].dest, 1'b1, a, rt);
            chk("vec_out_valid_latency", 32'(bus.out_valid), 32'd1);
            chk("vec_out_r", 32'(bus.out_r), 32'(vecs[i].r));
            idle_step(1'b1, rt);
            chk("vec_flag_o", 32'(bus.flag_o), 32'(vecs[i].exp_o));
            chk("vec_flag_n", 32'(bus.flag_n), 32'(vecs[i].exp_n));
            chk("vec_flag_z", 32'(bus.flag_z), 32'(vecs[i].exp_z));
            chk("vec_trap", 32'(bus.trap), 32'(TRAP_EN && vecs[i].exp_o));
            chk("vec_out_r_hold_empty", 32'(bus.out_r), 32'(vecs[i].r));
            idle_step(1'b1, rt);
            chk("vec_trap_one_cycle", 32'(bus.trap), 32'd0);
        end

        // Stall with three back-to-back inputs, then release.
        ra = 16'h1111; rb = 16'h2222; rc = 16'h3333;
        step(1'b1, ra, 1'b0, OP_AND, 4'h1, 1'b0, a, rt);
        step(1'b1, rb, 1'b0, OP_AND, 4'h2, 1'b0, a, rt);
        step(1'b1, rc, 1'b0, OP_AND, 4'h3, 1'b0, a, rt);
        chk("stall_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("stall_head_first", 32'(bus.out_r), 32'(ra));
        step(1'b1, rc, 1'b0, OP_AND, 4'h3, 1'b1, a, rt);
        chk("stall_second_head", 32'(bus.out_r), 32'(rb));
        chk("stall_ready_back", 32'(bus.in_ready), 32'd1);
        step(1'b1, rc, 1'b0, OP_AND, 4'h3, 1'b1, a, rt);
        chk("stall_third_accepted", 32'(a), 32'd1);
        chk("stall_third_head", 32'(bus.out_r), 32'(rc));
        drain();

        // Streaming at occupancy 1: one accept and one retire every cycle.
        step(1'b1, 16'h0100, 1'b0, OP_SLL, 4'h0, 1'b0, a, rt);
        nret = 0;
        for (int i = 1; i <= 10; i++) begin
            rv = 16'h0100 + 16'(i);
            step(1'b1, rv, 1'b0, OP_SLL, 4'(i), 1'b1, a, rt);
            if (rt) nret++;
            chk("stream_head", 32'(bus.out_r), 32'(rv));
        end
        chk("stream_retired", 32'(nret), 32'd10);
        chk("stream_occ", 32'(bus.dbg_occ), 32'd1);
        drain();

        // Overflow counter saturation (counts stay 0 without the trap build).
        for (int i = 0; i < 262; i++) step(1'b1, 16'h8000, 1'b1, OP_ADD, 4'h9, 1'b1, a, rt);
        drain();
        chk("ovf_cnt_saturated", 32'(bus.ovf_cnt), TRAP_EN ? 32'd255 : 32'd0);

        // Randomized traffic, biased toward zero and sign-boundary results.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = '0;
                1:       rv = 16'h8000;
                default: rv = WIDTH'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), DEST_W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), a, rt);
        end
        drain();

        // Asynchronous reset while full and stalled.
        step(1'b1, 16'h8000, 1'b1, OP_ADD, 4'h3, 1'b1, a, rt);
        step(1'b1, 16'h8001, 1'b1, OP_ADD, 4'h4, 1'b1, a, rt);
        step(1'b1, 16'h8002, 1'b1, OP_ADD, 4'h5, 1'b0, a, rt);
        step(1'b1, 16'h8003, 1'b1, OP_ADD, 4'h6, 1'b0, a, rt);
        chk("pre_reset_full", 32'(bus.dbg_occ), 32'd2);
        chk("pre_reset_flag_o", 32'(bus.flag_o), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_out_r", 32'(bus.out_r), 32'd0);
        chk("async_rst_out_dest", 32'(bus.out_dest), 32'd0);
        chk("async_rst_flags", 32'({bus.flag_o, bus.flag_n, bus.flag_z}), 32'd0);
        chk("async_rst_trap", 32'(bus.trap), 32'd0);
        chk("async_rst_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
        bus.in_valid = 0; bus.out_ready = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
        step(1'b1, 16'h0042, 1'b0, OP_OR, 4'ha, 1'b1, a, rt);
        chk("post_reset_first_accept", 32'(bus.out_r), 32'h42);
        drain();

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 16: datapath width of the ALU result.
REQ-002 Parameter DEST_W, default 4: destination-register tag width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  ALU result presented.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 in_r  input  WIDTH  ALU result R.
REQ-008 in_o  input  1  ALU overflow flag O.
REQ-009 in_crtl  input  4  ALU control code that produced in_r.
REQ-010 in_dest  input  DEST_W  destination register tag.
REQ-011 out_valid  output  1  head entry available to writeback.
REQ-012 out_ready  input  1  writeback consumes head entry.
REQ-013 out_r  output  WIDTH  head result.
REQ-014 out_dest  output  DEST_W  head destination tag.
REQ-015 flag_o, flag_n, flag_z  output  1 each  status register, last retired result.
REQ-016 trap  output  1  overflow trap pulse (see Configuration).
REQ-017 ovf_cnt  output  8  retired-overflow count (see Configuration).

Function
REQ-018 Accept occurs when in_valid && in_ready; retire occurs when out_valid && out_ready.
REQ-019 Storage is a 2-entry in-order buffer; in_ready = (occupancy != 2), out_valid = (occupancy != 0), both driven from registered state.
REQ-020 Latency from accept to out_valid is exactly 1 cycle when empty; no combinational path in_* -> out_*.
REQ-021 Per entry stored: r, dest, o_eff, n = r[WIDTH-1], z = (r == 0).
REQ-022 o_eff = in_o when in_crtl is 4'b1111 (add) or 4'b1110 (sub); otherwise 0.
REQ-023 Undefined control codes (0000, 0011-0111, 1100) are accepted and forwarded with o_eff = 0.
REQ-024 On retire, flag_o/flag_n/flag_z load the retired entry's o_eff/n/z; otherwise they hold.
REQ-025 Simultaneous accept and retire at occupancy 1: occupancy stays 1, new entry becomes head next cycle.
REQ-026 At occupancy 2, in_ready = 0; a retire frees one slot, in_ready rises the following cycle.
REQ-027 out_r/out_dest hold stable while out_valid && !out_ready.
REQ-028 At occupancy 0, out_r and out_dest hold their last value.

Reset
REQ-029 rst asserted at any time clears occupancy to 0, discards buffered entries, and forces out_valid=0, in_ready=1, out_r=0, out_dest=0, flag_o=flag_n=flag_z=0, trap=0, ovf_cnt=0.
REQ-030 First accept is permitted on the first rising clk after rst deasserts.

Configuration
REQ-031 Macro ALU_OVF_TRAP_EN defined: trap is high for exactly one cycle following each retire whose o_eff = 1, and ovf_cnt increments on each such retire, saturating at 255.
REQ-032 Macro ALU_OVF_TRAP_EN undefined: trap and ovf_cnt are constant 0, and no counter logic is present.

Structure
REQ-033 Shared package alu_pkg holds control-code constants (OP_ADD=1111, OP_SUB=1110, OP_AND=1101, OP_OR, OP_MUL=0001, OP_DIV=0010, OP_SLL=1010, OP_SRL=1011, OP_ROL=1000, OP_ROR=1001) and the buffer-entry struct.
REQ-034 One sub-module, res_fifo2, implements the 2-entry valid/ready buffer; flag computation and the trap counter stay in alu_result_stage.

Verification
REQ-035 Reset, then accept in_r=16'h0000, crtl=1101, out_ready=1 -> out_valid one cycle later; after retire flag_z=1, flag_n=0, flag_o=0.
REQ-036 Accept r=16'h8000, o=1, crtl=1111 then retire -> flag_o=1, flag_n=1, flag_z=0; with ALU_OVF_TRAP_EN trap pulses for 1 cycle and ovf_cnt=1.
REQ-037 Accept r=16'h8000, o=1, crtl=0001 -> after retire flag_o=0, trap stays 0.
REQ-038 out_ready=0, three back-to-back valid inputs -> in_ready low after 2 accepts; out_r holds the first value; release out_ready -> order preserved, third accepted one cycle later.
REQ-039 Occupancy 1 with simultaneous accept and retire each cycle for 10 cycles -> one result per cycle, no loss or duplication.
REQ-040 Assert rst with occupancy 2 mid-stall -> out_valid=0, in_ready=1, flags and ovf_cnt 0 immediately, without waiting for a clk edge.
